// File: rtl/bot_if_pkg.sv
// rtl/bot_if_pkg.sv - port map, reserved read constants and jump state type for the BOT register interface
package bot_if_pkg;

   localparam logic [3:0] PA_MOTCTL  = 4'd0;
   localparam logic [3:0] PA_LOCX    = 4'd1;
   localparam logic [3:0] PA_LOCY    = 4'd2;
   localparam logic [3:0] PA_BOTINFO = 4'd3;
   localparam logic [3:0] PA_SENSORS = 4'd4;
   localparam logic [3:0] PA_RSVD5   = 4'd5;
   localparam logic [3:0] PA_RSVD6   = 4'd6;
   localparam logic [3:0] PA_BOTCFG  = 4'd7;
   localparam logic [3:0] PA_MAPX    = 4'd8;
   localparam logic [3:0] PA_MAPY    = 4'd9;
   localparam logic [3:0] PA_MAPVAL  = 4'd10;
   localparam logic [3:0] PA_RSVD11  = 4'd11;
   localparam logic [3:0] PA_LDTGL   = 4'd12;
   localparam logic [3:0] PA_RSVD13  = 4'd13;
   localparam logic [3:0] PA_UPDSYS  = 4'd14;
   localparam logic [3:0] PA_JMPSTAT = 4'd15;

   localparam logic [7:0] RD_RSVD5  = 8'h55;
   localparam logic [7:0] RD_RSVD6  = 8'h66;
   localparam logic [7:0] RD_MAPX   = 8'h88;
   localparam logic [7:0] RD_MAPY   = 8'h99;
   localparam logic [7:0] RD_RSVD11 = 8'hBB;

   typedef enum logic {
      ST_GROUND = 1'b0,
      ST_AIR    = 1'b1
   } jump_state_e;

   // Horizontal wrap: the two edge columns publish as the opposite landing column.
   function automatic logic [7:0] wrap_x(input logic [7:0] x,
                                         input logic [7:0] right_edge,
                                         input logic [7:0] left_edge,
                                         input logic [7:0] left_land,
                                         input logic [7:0] right_land);
      if (x == right_edge)     return left_land;
      else if (x == left_edge) return right_land;
      else                     return x;
   endfunction

endpackage

// File: rtl/bot_jump_fsm.sv
// rtl/bot_jump_fsm.sv - jump state, descent prescaler and vertical offset counter
module bot_jump_fsm
   import bot_if_pkg::*;
#(
   parameter int JUMP_H      = 4,
   parameter int TICK_CYCLES = 800_000_000
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       load_i,
   input  logic       jump_req_i,
   output logic [3:0] offset_o,
   output logic [3:0] offset_next_o,
   output logic       in_air_o
);

   localparam int             PW        = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
   localparam logic [PW-1:0]  TICK_LAST = PW'(TICK_CYCLES - 1);
   localparam logic [3:0]     JUMP_OFS  = 4'(JUMP_H);

   jump_state_e   state_q, state_d;
   logic [3:0]    offset_q, offset_d;
   logic [PW-1:0] presc_q, presc_d;
   logic          tick;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q  <= ST_GROUND;
         offset_q <= 4'd0;
         presc_q  <= '0;
      end else begin
         state_q  <= state_d;
         offset_q <= offset_d;
         presc_q  <= presc_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      offset_d = offset_q;
      presc_d  = presc_q;
      tick     = 1'b0;
      case (state_q)
         ST_GROUND: begin
            presc_d = '0;
            if (load_i && jump_req_i) begin
               state_d  = ST_AIR;
               offset_d = JUMP_OFS;
            end
         end
         ST_AIR: begin
            // Jump requests are ignored here: no double jump.
            tick = (presc_q == TICK_LAST);
            if (tick) begin
               presc_d  = '0;
               offset_d = offset_q - 4'd1;
               if (offset_q == 4'd1) state_d = ST_GROUND;
            end else begin
               presc_d = presc_q + 1'b1;
            end
         end
         default: state_d = ST_GROUND;
      endcase
   end

   // The snapshot samples the offset this cycle's update will produce.
   assign offset_next_o = offset_d;
   assign offset_o      = offset_q;
   assign in_air_o      = (state_q == ST_AIR);

endmodule

// File: rtl/bot_jump_if.sv
// rtl/bot_jump_if.sv - BOT PicoBlaze port decode, holding registers and published snapshot
module bot_jump_if
   import bot_if_pkg::*;
#(
   parameter logic [7:0] X_RIGHT_EDGE = 8'h7D,
   parameter logic [7:0] X_LEFT_EDGE  = 8'h00,
   parameter logic [7:0] X_LEFT_LAND  = 8'h01,
   parameter logic [7:0] X_RIGHT_LAND = 8'h7B,
   parameter logic [7:0] JUMP_CODE    = 8'h40,
   parameter int         JUMP_H       = 4,
   parameter int         TICK_CYCLES  = 800_000_000
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       Wr_Strobe,
   input  logic       Rd_Strobe,
   input  logic [7:0] AddrIn,
   input  logic [7:0] DataIn,
   output logic [7:0] DataOut,
   input  logic [7:0] MotCtl,
   input  logic [7:0] BotConfig,
   input  logic [1:0] MapVal,
   output logic [7:0] LocX,
   output logic [7:0] LocY,
   output logic [7:0] BotInfo,
   output logic [7:0] Sensors,
   output logic [7:0] MapX,
   output logic [7:0] MapY,
   output logic       upd_sysregs,
   output logic       in_air
);

   logic [7:0] locx_int_q, locy_int_q, botinfo_int_q, sensors_int_q;
   logic [7:0] mapx_q, mapy_q;
   logic [7:0] locx_q, locy_q, botinfo_q, sensors_q;
   logic [7:0] dout_q, dout_d, locy_d, locx_wrapped;
   logic       ld_tgl_q, ld_tgl_dly_q, upd_q, load;
   logic [3:0] offset, offset_next;
   logic [8:0] locy_diff;
   logic [3:0] port;
   logic       unused_ok;

   assign port      = AddrIn[3:0];
   assign unused_ok = &{1'b0, Rd_Strobe, AddrIn[7:4]};
   assign load      = ld_tgl_q ^ ld_tgl_dly_q;

   assign locx_wrapped = wrap_x(locx_int_q, X_RIGHT_EDGE, X_LEFT_EDGE, X_LEFT_LAND, X_RIGHT_LAND);

   bot_jump_fsm #(
      .JUMP_H      (JUMP_H),
      .TICK_CYCLES (TICK_CYCLES)
   ) u_jump_fsm (
      .clk           (clk),
      .reset         (reset),
      .load_i        (load),
      .jump_req_i    (botinfo_int_q == JUMP_CODE),
      .offset_o      (offset),
      .offset_next_o (offset_next),
      .in_air_o      (in_air)
   );

   // Jump lifts the bot upward, i.e. toward row 0; clamp at the top row.
   assign locy_diff = {1'b0, locy_int_q} - {5'b0, offset_next};
   assign locy_d    = locy_diff[8] ? 8'h00 : locy_diff[7:0];

   always_comb begin
      dout_d = 8'h00;
      case (port)
         PA_MOTCTL:  dout_d = MotCtl;
         PA_LOCX:    dout_d = locx_wrapped;
         PA_LOCY:    dout_d = locy_int_q;
         PA_BOTINFO: dout_d = botinfo_int_q;
         PA_SENSORS: dout_d = sensors_int_q;
         PA_RSVD5:   dout_d = RD_RSVD5;
         PA_RSVD6:   dout_d = RD_RSVD6;
         PA_BOTCFG:  dout_d = BotConfig;
         PA_MAPX:    dout_d = RD_MAPX;
         PA_MAPY:    dout_d = RD_MAPY;
         PA_MAPVAL:  dout_d = {6'b0, MapVal};
         PA_RSVD11:  dout_d = RD_RSVD11;
         PA_JMPSTAT: dout_d = {in_air, 3'b0, offset};
         default:    dout_d = 8'h00;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         locx_int_q    <= 8'h00;
         locy_int_q    <= 8'h00;
         botinfo_int_q <= 8'h00;
         sensors_int_q <= 8'h00;
         mapx_q        <= 8'h00;
         mapy_q        <= 8'h00;
         ld_tgl_q      <= 1'b0;
         ld_tgl_dly_q  <= 1'b0;
         upd_q         <= 1'b0;
         locx_q        <= 8'h00;
         locy_q        <= 8'h00;
         botinfo_q     <= 8'h00;
         sensors_q     <= 8'h00;
         dout_q        <= 8'h00;
      end else begin
         dout_q       <= dout_d;
         ld_tgl_dly_q <= ld_tgl_q;
         if (Wr_Strobe) begin
            case (port)
               PA_LOCX:    locx_int_q    <= DataIn;
               PA_LOCY:    locy_int_q    <= DataIn;
               PA_BOTINFO: botinfo_int_q <= DataIn;
               PA_SENSORS: sensors_int_q <= DataIn;
               PA_MAPX:    mapx_q        <= DataIn;
               PA_MAPY:    mapy_q        <= DataIn;
               PA_LDTGL:   ld_tgl_q      <= ~ld_tgl_q;
               PA_UPDSYS:  upd_q         <= ~upd_q;
               default:    ;
            endcase
         end
         if (load) begin
            locx_q    <= locx_wrapped;
            locy_q    <= locy_d;
            botinfo_q <= botinfo_int_q;
            sensors_q <= sensors_int_q;
         end
      end
   end

   assign DataOut     = dout_q;
   assign LocX        = locx_q;
   assign LocY        = locy_q;
   assign BotInfo     = botinfo_q;
   assign Sensors     = sensors_q;
   assign MapX        = mapx_q;
   assign MapY        = mapy_q;
   assign upd_sysregs = upd_q;

endmodule

// File: tb/tb_bot_jump_if.sv
// tb/tb_bot_jump_if.sv - scoreboard bench for bot_jump_if with directed vectors
module tb_bot_jump_if;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       Wr_Strobe = 1'b0;
   logic       Rd_Strobe = 1'b0;
   logic [7:0] AddrIn = 8'h0C;
   logic [7:0] DataIn = 8'h00;
   logic [7:0] MotCtl = 8'hA5;
   logic [7:0] BotConfig = 8'h3C;
   logic [1:0] MapVal = 2'b10;
   logic [7:0] DataOut, LocX, LocY, BotInfo, Sensors, MapX, MapY;
   logic       upd_sysregs, in_air;

   bot_jump_if #(
      .TICK_CYCLES (10)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .Wr_Strobe   (Wr_Strobe),
      .Rd_Strobe   (Rd_Strobe),
      .AddrIn      (AddrIn),
      .DataIn      (DataIn),
      .DataOut     (DataOut),
      .MotCtl      (MotCtl),
      .BotConfig   (BotConfig),
      .MapVal      (MapVal),
      .LocX        (LocX),
      .LocY        (LocY),
      .BotInfo     (BotInfo),
      .Sensors     (Sensors),
      .MapX        (MapX),
      .MapY        (MapY),
      .upd_sysregs (upd_sysregs),
      .in_air      (in_air)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      int         due;
      int         sel;
      logic [7:0] exp;
      string      name;
   } exp_t;

   exp_t       sb[$];
   int         checks = 0;
   int         errors = 0;
   logic [7:0] mon_act;

   function automatic logic [7:0] pick(input int sel);
      case (sel)
         0:       return LocX;
         1:       return LocY;
         2:       return BotInfo;
         3:       return Sensors;
         4:       return DataOut;
         5:       return {7'b0, in_air};
         6:       return {7'b0, upd_sysregs};
         7:       return MapX;
         default: return MapY;
      endcase
   endfunction

   always @(negedge clk) begin
      for (int i = sb.size() - 1; i >= 0; i--) begin
         if (sb[i].due == cyc) begin
            mon_act = pick(sb[i].sel);
            checks++;
            if (mon_act !== sb[i].exp) begin
               errors++;
               $display("FAIL %s: got %02h expected %02h (cycle %0d)",
                        sb[i].name, mon_act, sb[i].exp, cyc);
            end
            sb.delete(i);
         end
      end
   end

   task automatic push(input int due, input int sel, input logic [7:0] v, input string n);
      exp_t e;
      e.due  = due;
      e.sel  = sel;
      e.exp  = v;
      e.name = n;
      sb.push_back(e);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic wr(input logic [7:0] a, input logic [7:0] d);
      Wr_Strobe = 1'b1;
      AddrIn    = a;
      DataIn    = d;
      step();
      Wr_Strobe = 1'b0;
      AddrIn    = 8'h0C;
   endtask

   task automatic rd(input logic [7:0] a, input logic [7:0] e, input string n);
      AddrIn = a;
      push(cyc + 1, 4, e, n);
      step();
      AddrIn = 8'h0C;
   endtask

   logic [7:0] rd_exp [16] = '{8'hA5, 8'h7B, 8'h30, 8'h00, 8'h5A, 8'h55, 8'h66, 8'h3C,
                               8'h88, 8'h99, 8'h02, 8'hBB, 8'h00, 8'h00, 8'h00, 8'h00};
   int w;

   initial begin
      step();
      step();
      push(cyc, 0, 8'h00, "rst_locx");
      push(cyc, 1, 8'h00, "rst_locy");
      push(cyc, 6, 8'h00, "rst_upd");
      reset = 1'b0;
      push(cyc + 1, 4, 8'h00, "rst_dout");
      push(cyc + 1, 5, 8'h00, "rst_inair");
      step();
      step();

      wr(8'd1, 8'h20);
      wr(8'd2, 8'h30);
      wr(8'd12, 8'h00);
      push(cyc, 0, 8'h00, "snap_pre");
      push(cyc + 1, 0, 8'h20, "snap_locx");
      push(cyc + 1, 1, 8'h30, "snap_locy");
      push(cyc + 5, 0, 8'h20, "snap_hold_x");
      push(cyc + 5, 1, 8'h30, "snap_hold_y");
      repeat (6) step();

      wr(8'd1, 8'h7D);
      wr(8'd12, 8'h00);
      push(cyc + 1, 0, 8'h01, "wrap_right");
      step();
      rd(8'd1, 8'h01, "rd_wrap");
      wr(8'd1, 8'h00);
      wr(8'd12, 8'h00);
      push(cyc + 1, 0, 8'h7B, "wrap_left");
      repeat (2) step();

      wr(8'd14, 8'h00);
      push(cyc, 6, 8'h01, "upd_1");
      wr(8'd14, 8'h00);
      push(cyc, 6, 8'h00, "upd_0");
      wr(8'd8, 8'h12);
      push(cyc, 7, 8'h12, "mapx");
      wr(8'd9, 8'h34);
      push(cyc, 8, 8'h34, "mapy");
      wr(8'd4, 8'h5A);
      step();

      checks++;
      if (MapX !== 8'h12) begin
         errors++;
         $display("FAIL mapx_direct: got %02h expected 12", MapX);
      end
      checks++;
      if (MapY !== 8'h34) begin
         errors++;
         $display("FAIL mapy_direct: got %02h expected 34", MapY);
      end
      checks++;
      if (upd_sysregs !== 1'b0) begin
         errors++;
         $display("FAIL upd_direct: got %b expected 0", upd_sysregs);
      end

      for (int p = 0; p < 16; p++) rd(8'(p), rd_exp[p], $sformatf("rd_port%0d", p));
      step();

      wr(8'd3, 8'h40);
      w = cyc;
      push(w + 2,  1, 8'h2C, "jmp_top");
      push(w + 2,  5, 8'h01, "jmp_air");
      push(w + 10, 1, 8'h2C, "jmp_no_double");
      push(w + 11, 1, 8'h2C, "jmp_pre_tick1");
      push(w + 12, 1, 8'h2D, "jmp_row1");
      push(w + 22, 1, 8'h2E, "jmp_row2");
      push(w + 32, 1, 8'h2F, "jmp_row3");
      push(w + 41, 5, 8'h01, "jmp_air_last");
      push(w + 42, 1, 8'h30, "jmp_row4");
      push(w + 42, 5, 8'h00, "jmp_land");
      push(w + 45, 2, 8'h00, "jmp_info");
      for (int i = 0; i < 50; i++) begin
         Wr_Strobe = 1'b1;
         if (i == 5) begin
            AddrIn = 8'd3;
            DataIn = 8'h00;
         end else begin
            AddrIn = 8'd12;
         end
         step();
      end
      Wr_Strobe = 1'b0;
      AddrIn    = 8'h0C;
      step();

      wr(8'd2, 8'h02);
      wr(8'd3, 8'h40);
      wr(8'd14, 8'h00);
      wr(8'd12, 8'h00);
      push(cyc + 1, 1, 8'h00, "sat_locy");
      push(cyc + 1, 5, 8'h01, "sat_air");
      push(cyc + 1, 3, 8'h5A, "sensors");
      step();
      rd(8'd15, 8'h84, "rd_jstat");
      step();

      reset = 1'b1;
      push(cyc, 0, 8'h00, "rst2_locx");
      push(cyc, 2, 8'h00, "rst2_info");
      push(cyc, 5, 8'h00, "rst2_inair");
      push(cyc, 6, 8'h00, "rst2_upd");
      step();
      step();
      reset = 1'b0;
      push(cyc + 1, 4, 8'h00, "rst2_dout");
      step();
      rd(8'd15, 8'h00, "rd_jstat_rst");
      repeat (3) step();

      checks++;
      if (LocY !== 8'h00) begin
         errors++;
         $display("FAIL rst2_locy_direct: got %02h expected 00", LocY);
      end
      checks++;
      if (in_air !== 1'b0) begin
         errors++;
         $display("FAIL rst2_inair_direct: got %b expected 0", in_air);
      end
      checks++;
      if (LocX !== 8'h00) begin
         errors++;
         $display("FAIL rst2_locx_direct: got %02h expected 00", LocX);
      end

      while (sb.size() > 0) begin
         checks++;
         errors++;
         $display("FAIL %s: never sampled, expected %02h", sb[0].name, sb[0].exp);
         void'(sb.pop_front());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/bot_jump_if.md
# bot_jump_if

Parametrised second-generation PicoBlaze register interface for the Rojobot sidescroller. It decodes the 16 I/O ports written and read by the BOT PicoBlaze, holds the internal location, info and sensor registers, and publishes a consistent snapshot to the system on each load-toggle edge. On the way out it applies configurable horizontal wrap-around and a timed jump/fall vertical offset. It sits between the BOT PicoBlaze and the map, display and application logic, replacing the fixed-constant interface.

## Interface
- `X_RIGHT_EDGE`, default 8'h7D: internal X that wraps to the left landing column.
- `X_LEFT_EDGE`, default 8'h00: internal X that wraps to the right landing column.
- `X_LEFT_LAND`, default 8'h01: published X when the bot is at `X_RIGHT_EDGE`.
- `X_RIGHT_LAND`, default 8'h7B: published X when the bot is at `X_LEFT_EDGE`.
- `JUMP_CODE`, default 8'h40: BotInfo value that requests a jump.
- `JUMP_H`, default 4: initial upward offset in rows (range 1–15).
- `TICK_CYCLES`, default 800_000_000: clock cycles per one-row descent (≥2).
- `clk`, in, 1: system clock. Single clock domain.
- `reset`, in, 1: asynchronous, active-high reset.
- `Wr_Strobe`, in, 1: PicoBlaze write strobe.
- `Rd_Strobe`, in, 1: PicoBlaze read strobe. Unused functionally.
- `AddrIn`, in, 8: port address. Only bits [3:0] are decoded.
- `DataIn`, in, 8: write data.
- `DataOut`, out, 8: registered read data.
- `MotCtl`, in, 8: motor control, port 0.
- `BotConfig`, in, 8: configuration, port 7.
- `MapVal`, in, 2: map value, port 10. Zero-extended on read.
- `LocX`, `LocY`, `BotInfo`, `Sensors`, out, 8 each: published snapshot.
- `MapX`, `MapY`, out, 8 each: map address, ports 8 and 9.
- `upd_sysregs`, out, 1: toggles on each write to port 14.
- `in_air`, out, 1: high while the jump offset is non-zero.

## Operation
- **Writes** (Wr_Strobe=1, AddrIn[3:0]):
  - Port 1 → LocX_int, 2 → LocY_int, 3 → BotInfo_int, 4 → Sensors_int.
  - Port 8 → MapX, 9 → MapY.
  - Port 12 toggles `ld_tgl`. Port 14 toggles `upd_sysregs`.
  - All other ports are ignored.
- **Wrap function** `wx(x)`: returns X_LEFT_LAND if x == X_RIGHT_EDGE, X_RIGHT_LAND if x == X_LEFT_EDGE, otherwise x.
- **Reads** (registered every cycle, independent of Rd_Strobe):
  - Port 0: MotCtl. Port 1: wx(LocX_int). Port 2: LocY_int. Port 3: BotInfo_int. Port 4: Sensors_int.
  - Port 5: 8'h55. Port 6: 8'h66. Port 7: BotConfig.
  - Port 8: 8'h88. Port 9: 8'h99. Port 10: {6'b0, MapVal}. Port 11: 8'hBB.
  - Ports 12, 13, 14: 8'h00.
  - Port 15: {in_air, 3'b0, offset[3:0]}.
- **Snapshot**: `ld_tgl` is delayed by one flop. `load` is high for one cycle when `ld_tgl` differs from its delayed copy. On `load`:
  - LocX ← wx(LocX_int).
  - LocY ← LocY_int − offset_next, saturating at 0.
  - BotInfo ← BotInfo_int. Sensors ← Sensors_int.
  - Between loads, all published registers hold their value.
- **Jump FSM** (states GROUND, AIR; `offset` is a 4-bit counter; `tick` is the terminal count of a prescaler):
  - GROUND: when `load` is high and BotInfo_int == JUMP_CODE, go to AIR, set offset = JUMP_H, clear the prescaler. offset_next equals JUMP_H on that same load.
  - AIR: the prescaler counts 0..TICK_CYCLES−1. On each `tick`, offset decrements by 1. When offset reaches 0, go to GROUND.
  - AIR: a jump request is ignored (no double jump).
  - GROUND: the prescaler is held at 0.
  - `in_air` = (state == AIR).
  - LocY updates only on `load`. A descent tick becomes visible at the next snapshot.
- **Simultaneous events**:
  - A write to port 12 in the same cycle as `load` still toggles `ld_tgl`. This produces the next `load` normally.
  - A `tick` in the same cycle as `load`: `load` uses the post-decrement offset.
- **Reset** (asynchronous, any time, including mid-jump): all outputs and internal registers go to 0, including DataOut, `upd_sysregs` and `ld_tgl`. State returns to GROUND, offset 0, prescaler 0.

## Timing
- Read latency is 1 cycle: AddrIn stable in cycle N gives DataOut valid in cycle N+1.
- A write is captured at the clock edge ending the Wr_Strobe cycle.
- Port 12 write in cycle N: `ld_tgl` flips at the end of N, `load` is high in N+1, and published registers change at the end of N+1.
- Descent from a jump: row k returns after k·TICK_CYCLES cycles. The full landing takes JUMP_H·TICK_CYCLES cycles after the jump load.

## Structure
- Package `bot_if_pkg` holds:
  - Port address localparams (PA_LOCX … PA_UPDSYS).
  - Reserved read constants (8'h55, 8'h66, 8'h88, 8'h99, 8'hBB).
  - The FSM state typedef.
- Sub-module `bot_jump_fsm` contains the prescaler, offset counter and state, and produces `offset` and `in_air`. Its inputs are `load`, `jump_req` and the parameters.
- The parent module holds the port decode, holding registers, edge detect and snapshot logic.

## Test plan
- **Reset**: assert reset mid-operation → all outputs 0, in_air=0, DataOut=0 one cycle after deassert.
- **Snapshot**: write port 1=8'h20, port 2=8'h30, then write port 12 → LocX=8'h20, LocY=8'h30 two cycles after the port-12 write. No change on further idle cycles.
- **Wrap**: write LocX_int=8'h7D and load → LocX=8'h01, and port-1 readback=8'h01. Write LocX_int=8'h00 and load → LocX=8'h7B.
- **Jump** (TICK_CYCLES=10): BotInfo_int=8'h40, LocY_int=8'h30, load → LocY=8'h2C, in_air=1. Load every cycle → LocY steps 2D, 2E, 2F, 30 at 10-cycle intervals, then in_air=0.
- **Double jump and saturation**: a jump request while AIR → offset unchanged. LocY_int=2 with jump → LocY=0.
- **Toggles and reads**: write port 14 twice → upd_sysregs goes 1, then 0. Sweep reads of ports 0–15 → the constants listed in Operation, with MapVal=2'b10 giving 8'h02.
